// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the pointer synchroniser, the sending-side
// encoder and the bench model.
//   gray2bin(g, w) : decode the low w bits of g (MSB-first XOR chain)
//   bin2gray(b, w) : encode the low w bits of b
// Both work on a 64-bit carrier; bits at and above w are returned as 0.
package gray_pkg;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    logic [MAX_W-1:0] m;
    if (w >= MAX_W) m = '1;
    else            m = (64'd1 << w) - 64'd1;
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    // Bits above w are zero after masking, so the chain naturally starts
    // with b[w-1] = g[w-1].
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i == MAX_W - 1) b[i] = gm[i];
      else                b[i] = gm[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input int w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser. Kept as its own module so CDC constraints
// can target it by name. No logic between stages.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears every stage
//   d_i     : W-bit input from the foreign domain
//   q_o     : output of the last stage
module sync_chain #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q_o = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Receive-side Gray pointer stage: synchronises a foreign-domain Gray
// vector, decodes it to binary, and reports update pulses, the modulo
// forward step and a sticky flag for steps larger than MAX_STEP.
// Ports:
//   clk      : local clock
//   reset_n  : asynchronous active-low reset
//   gray_i   : Gray vector from the sending domain (one bit changes per update)
//   clr_i    : synchronous clear of jump_o (a new jump at the same edge wins)
//   bin_o    : registered binary value
//   delta_o  : registered (new - previous) mod 2^VEC_W
//   upd_o    : one-cycle pulse when bin_o changes
//   jump_o   : sticky, set when the step exceeds MAX_STEP
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int VEC_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [VEC_W-1:0] gray_i,
  input  logic             clr_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] delta_o,
  output logic             upd_o,
  output logic             jump_o
);

  localparam logic [63:0] MAX_STEP_U = 64'(MAX_STEP);

  logic [VEC_W-1:0] g_s;
  logic [VEC_W-1:0] b;
  logic [VEC_W-1:0] delta_next;
  logic             jump_set;

  sync_chain #(
    .W      (VEC_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (gray_i),
    .q_o     (g_s)
  );

  // Decode of the synchronised sample
  assign b          = VEC_W'(gray2bin(64'(g_s), VEC_W));
  // Wrap-around subtraction: the carry out is deliberately dropped
  assign delta_next = b - bin_o;
  assign jump_set   = (64'(delta_next) > MAX_STEP_U);

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_o   <= '0;
      delta_o <= '0;
      upd_o   <= 1'b0;
      jump_o  <= 1'b0;
    end else begin
      bin_o   <= b;
      delta_o <= delta_next;
      upd_o   <= (b != bin_o);
      jump_o  <= jump_set | (jump_o & ~clr_i);
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: a default instance (A) and one with
// SYNC_STAGES=3, MAX_STEP=4 (B) sharing clock and reset.
module tb_gray_ptr_sync;
  import gray_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] gray_a, gray_b;
  logic       clr_a, clr_b;
  logic [3:0] bin_a, delta_a, bin_b, delta_b;
  logic       upd_a, jump_a, upd_b, jump_b;

  int n_cmp = 0;
  int n_bad = 0;

  gray_ptr_sync #(.VEC_W(4), .SYNC_STAGES(2), .MAX_STEP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .gray_i(gray_a), .clr_i(clr_a),
    .bin_o(bin_a), .delta_o(delta_a), .upd_o(upd_a), .jump_o(jump_a)
  );

  gray_ptr_sync #(.VEC_W(4), .SYNC_STAGES(3), .MAX_STEP(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .gray_i(gray_b), .clr_i(clr_b),
    .bin_o(bin_b), .delta_o(delta_b), .upd_o(upd_b), .jump_o(jump_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gray;
    logic       clr;
    logic [3:0] bin;
    logic [3:0] delta;
    logic       upd;
    logic       jump;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] eb, input logic [3:0] ed,
                       input logic eu, input logic ej);
    chk({tag, ".bin"},   64'(bin_a),   64'(eb));
    chk({tag, ".delta"}, 64'(delta_a), 64'(ed));
    chk({tag, ".upd"},   64'(upd_a),   64'(eu));
    chk({tag, ".jump"},  64'(jump_a),  64'(ej));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] eb, input logic [3:0] ed,
                       input logic eu, input logic ej);
    chk({tag, ".bin"},   64'(bin_b),   64'(eb));
    chk({tag, ".delta"}, 64'(delta_b), 64'(ed));
    chk({tag, ".upd"},   64'(upd_b),   64'(eu));
    chk({tag, ".jump"},  64'(jump_b),  64'(ej));
  endtask

  initial begin
    int pulses;

    // gray, clr | bin, delta, upd, jump  (outputs sampled after the edge
    // that follows applying the row's inputs; bin lags gray by 3 edges)
    tbl[0]  = '{4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0001, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0001, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{4'b0001, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0110, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0110, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0110, 1'b0, 4'd4, 4'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'b0110, 1'b0, 4'd4, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{4'b0110, 1'b0, 4'd4, 4'd0, 1'b0, 1'b1};
    tbl[10] = '{4'b0110, 1'b0, 4'd4, 4'd0, 1'b0, 1'b1};
    tbl[11] = '{4'b0110, 1'b0, 4'd4, 4'd0, 1'b0, 1'b1};
    tbl[12] = '{4'b0110, 1'b1, 4'd4, 4'd0, 1'b0, 1'b0};
    tbl[13] = '{4'b0110, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0};
    tbl[14] = '{4'b0100, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0};
    tbl[15] = '{4'b0100, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0};
    tbl[16] = '{4'b0100, 1'b1, 4'd7, 4'd3, 1'b1, 1'b1};
    tbl[17] = '{4'b0100, 1'b0, 4'd7, 4'd0, 1'b0, 1'b1};
    tbl[18] = '{4'b0100, 1'b1, 4'd7, 4'd0, 1'b0, 1'b0};

    gray_a  = '0; gray_b = '0;
    clr_a   = 1'b0; clr_b = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk_a("rst_a", 4'd0, 4'd0, 1'b0, 1'b0);
    chk_b("rst_b", 4'd0, 4'd0, 1'b0, 1'b0);
    step(); step();
    reset_n = 1'b1;

    // Idle after reset: nothing moves
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (upd_a) pulses++;
    end
    chk_a("idle", 4'd0, 4'd0, 1'b0, 1'b0);
    chk("idle.upd_count", 64'(pulses), 64'd0);

    // Full Gray walk including the 15 -> 0 wrap
    pulses = 0;
    for (int v = 1; v <= 16; v++) begin
      gray_a = 4'(bin2gray(64'(v % 16), 4));
      for (int c = 1; c <= 4; c++) begin
        step();
        if (upd_a) pulses++;
        if (c == 3) chk_a($sformatf("walk%0d", v), 4'(v % 16), 4'd1, 1'b1, 1'b0);
        if (c == 4) chk(  $sformatf("walk%0d.upd_low", v), 64'(upd_a), 64'd0);
      end
    end
    chk("walk.upd_count", 64'(pulses), 64'd16);
    chk("walk.jump", 64'(jump_a), 64'd0);

    // Step, jump, hold, clear, jump with simultaneous clear
    for (int k = 0; k < 19; k++) begin
      gray_a = tbl[k].gray;
      clr_a  = tbl[k].clr;
      step();
      chk_a($sformatf("tbl%0d", k), tbl[k].bin, tbl[k].delta, tbl[k].upd, tbl[k].jump);
    end
    clr_a = 1'b0;

    // Reach binary 9, then reset between edges
    gray_a = 4'b1101;
    step(); step(); step();
    chk("pre_rst.bin", 64'(bin_a), 64'd9);
    #3 reset_n = 1'b0;
    #1;
    chk_a("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    chk_a("rst_hold", 4'd0, 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    chk_a("rel1", 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    chk_a("rel2", 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    chk_a("rel3", 4'd9, 4'd9, 1'b1, 1'b1);

    // Instance B: 3-stage sync, MAX_STEP = 4
    gray_b = 4'b0011;                       // binary 2
    step(); step(); step(); step();
    chk_b("b2", 4'd2, 4'd2, 1'b1, 1'b0);
    step();
    gray_b = 4'b0101;                       // binary 6
    step(); step(); step();
    chk("b6.latency_bin", 64'(bin_b), 64'd2);
    step();
    chk_b("b6", 4'd6, 4'd4, 1'b1, 1'b0);
    step();
    gray_b = 4'b1110;                       // binary 11
    step(); step(); step(); step();
    chk_b("b11", 4'd11, 4'd5, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Receive-side stage for Gray-coded counters and pointers, such as async FIFO read/write pointers. It synchronises a Gray-code vector from a foreign clock domain into the local `clk` domain and decodes it back to binary. It also reports per-sample updates, the modulo step size, and a sticky error flag for illegal jumps. It sits directly downstream of the binary-to-Gray encoder, which lives in the sending domain.

## Interface
Parameters:
- `VEC_W`, 4: width of the Gray/binary vector, ≥ 1.
- `SYNC_STAGES`, 2: synchroniser flop depth, ≥ 2.
- `MAX_STEP`, 1: largest legal modulo-2^VEC_W forward step between consecutive samples.

Ports:
- `clk` in, 1: sole clock; all flops rising-edge.
- `reset_n` in, 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` and handled externally.
- `gray_i` in, VEC_W: Gray vector from the foreign domain. Asynchronous to `clk`; at most one bit changes per source update.
- `clr_i` in, 1: synchronous clear of `jump_o`.
- `bin_o` out, VEC_W: registered binary decode of the synchronised Gray value.
- `delta_o` out, VEC_W: registered (new − previous) binary value, mod 2^VEC_W.
- `upd_o` out, 1: one-cycle pulse when `bin_o` changes.
- `jump_o` out, 1: sticky flag, set when `delta_o` > `MAX_STEP`.

## Operation
- Synchroniser: `gray_i` passes through a chain of `SYNC_STAGES` flops. Only the last stage output `g_s` is used downstream; no logic sits between stages.
- Decode: `b = gray2bin(g_s)`, where `b[VEC_W-1] = g_s[VEC_W-1]` and `b[i] = b[i+1] ^ g_s[i]`. Purely combinational, MSB-first chain.
- Registered stage, every `clk` edge:
  - `bin_o <= b`.
  - `delta_o <= b - bin_o`, VEC_W-bit wrap-around subtraction with no carry out. The 15 → 0 transition at VEC_W=4 gives delta 1.
  - `upd_o <= (b != bin_o)`.
  - `jump_o <= (delta_next > MAX_STEP) | (jump_o & ~clr_i)`. A set and `clr_i` in the same cycle: set wins.
- Unchanged sample: `delta_o` = 0, `upd_o` = 0, and `jump_o` keeps its value unless `clr_i` is high.
- No state machine; the block is a pure pipeline plus the sticky flag.

## Timing
- Reset values: all synchroniser flops 0, `bin_o` = 0, `delta_o` = 0, `upd_o` = 0, `jump_o` = 0.
- Latency: `SYNC_STAGES + 1` rising edges from `gray_i` being stable at an edge to `bin_o`/`delta_o`/`upd_o` reflecting it. The default is 3.
- `upd_o` is high for exactly one cycle per changed sample. Back-to-back changes give back-to-back pulses.
- `clr_i` takes effect at the next edge, so `jump_o` reads 0 one cycle after `clr_i`, unless a new jump is detected at that same edge.
- Reset mid-operation: all outputs go to 0 asynchronously on `reset_n` low and stay there until the first edge after release.
- First sample after reset: the compare is against `bin_o` = 0. A nonzero `gray_i` present at reset release therefore produces `upd_o` and may set `jump_o`; this is intended, and software clears it with `clr_i`.

## Structure
- Shared package `gray_pkg`:
  - `gray2bin` function, VEC_W-parametric via an automatic function with a width argument or a parameterised class.
  - Matching `bin2gray` function, for reuse by the encoder and the bench model.
- Sub-module `sync_chain` (params `W`, `STAGES`; ports `clk`, `reset_n`, `d_i`, `q_o`): the plain flop chain. It is isolated for CDC tool constraints and reuse.
- Top `gray_ptr_sync` contains only `sync_chain`, the decode, and the output register stage.

## Test plan
Defaults are VEC_W=4, SYNC_STAGES=2, MAX_STEP=1 unless stated.
1. Reset, then `reset_n` high with `gray_i` = 0000 for 10 cycles → all outputs 0 and `upd_o` never asserted.
2. `gray_i` 0000 → 0001, held → 3 edges later `bin_o` = 1, `delta_o` = 1, `upd_o` pulses one cycle, `jump_o` = 0.
3. Walk `gray_i` through all 16 codes in Gray order, one every 4 cycles, including the wrap 1000 → 0000 → `bin_o` goes 0..15 then 0, every `delta_o` = 1, 16 `upd_o` pulses, `jump_o` stays 0.
4. From `bin_o` = 1, set `gray_i` = 0110 (binary 4) → `delta_o` = 3 and `jump_o` = 1, held over 5 idle cycles.
   - `clr_i` for one cycle → `jump_o` = 0 the next cycle.
   - Repeat the jump with `clr_i` high at the setting edge → `jump_o` = 1.
5. With `bin_o` = 9, pull `reset_n` low between edges → all outputs 0 before the next edge.
   - Release with `gray_i` = 1101 (binary 9) → `bin_o` = 9, `delta_o` = 9, `jump_o` = 1 after 3 edges.
6. SYNC_STAGES=3, MAX_STEP=4: step `gray_i` from binary 2 to binary 6 → `bin_o` updates after 4 edges, `delta_o` = 4, `jump_o` = 0. Then binary 6 → 11 → `delta_o` = 5, `jump_o` = 1.
